// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between the EX stage and the shared WIDTH-bit divider.
// It accepts a DIV from EX, stalls the pipeline and launches the divider.
// When the divider reports ready, it writes {remainder, quotient} into HI/LO.
// A zero divisor is resolved locally without launching the divider.
// After a flush, the result of the in-flight divide is drained and discarded.
// A divider that never completes raises a one-cycle timeout.
module div_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_div_valid,
    input  logic [WIDTH-1:0]   ex_dividend,
    input  logic [WIDTH-1:0]   ex_divisor,
    input  logic               flush,
    output logic               stall,
    output logic               div_start,
    output logic [WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]   div_divisor,
    input  logic               div_ready,
    input  logic [2*WIDTH-1:0] div_result,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               hilo_we,
    output logic               div_by_zero,
    output logic               timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT,
        S_WB,
        S_DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    // Set when DRAIN is entered straight from LAUNCH. The first DRAIN cycle is
    // then the post-start cycle, in which div_ready may still be stale.
    logic          drain_guard;
    logic          limit_hit;

    assign limit_hit = (wait_cnt == CW'(MAX_WAIT - 1));

    // Hold IF/ID/EX while a DIV is pending. WB releases the completing instruction.
    assign stall = ex_div_valid & ~flush & (state != S_WB);

    // Sequencer state, operand latches, HI/LO and the registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            drain_guard  <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            hi           <= '0;
            lo           <= '0;
            hilo_we      <= 1'b0;
            div_by_zero  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            // NOTE: the pulse outputs default low on every edge. Each state raises a
            // pulse only for the cycle it needs, so there are no clear-down paths to miss.
            div_start   <= 1'b0;
            hilo_we     <= 1'b0;
            div_by_zero <= 1'b0;
            timeout     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (ex_div_valid && !flush) begin
                        div_dividend <= ex_dividend;
                        div_divisor  <= ex_divisor;
                        if (ex_divisor == '0) begin
                            hi          <= ex_dividend;
                            lo          <= '1;
                            hilo_we     <= 1'b1;
                            div_by_zero <= 1'b1;
                            state       <= S_WB;
                        end else begin
                            div_start <= 1'b1;
                            state     <= S_LAUNCH;
                        end
                    end
                end

                S_LAUNCH: begin
                    wait_cnt <= '0;
                    if (flush) begin
                        drain_guard <= 1'b1;
                        state       <= S_DRAIN;
                    end else begin
                        state <= S_ARM;
                    end
                end

                // Any div_ready seen here belongs to the previous operation.
                S_ARM: begin
                    wait_cnt    <= '0;
                    drain_guard <= 1'b0;
                    state       <= flush ? S_DRAIN : S_WAIT;
                end

                S_WAIT: begin
                    if (flush) begin
                        wait_cnt <= '0;
                        state    <= S_DRAIN;
                    end else if (div_ready) begin
                        hi      <= div_result[2*WIDTH-1:WIDTH];
                        lo      <= div_result[WIDTH-1:0];
                        hilo_we <= 1'b1;
                        state   <= S_WB;
                    end else if (limit_hit) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // The DIV has retired, so a flush here does not cancel the write.
                S_WB: begin
                    state <= S_IDLE;
                end

                // The divider may not be restarted while it is busy. Wait for it to
                // finish, then throw the result away.
                S_DRAIN: begin
                    if (drain_guard) begin
                        drain_guard <= 1'b0;
                    end else if (div_ready) begin
                        state <= S_IDLE;
                    end else if (limit_hit) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: table-driven bench for div_ctrl. It uses a behavioural divider
// whose ready stays high after a result until the next start, and only drops one
// cycle after that start. Expected HI/LO writes go into a queue and are popped
// whenever hilo_we fires.
module tb_div_ctrl;

    localparam int W  = 16;
    localparam int MW = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ex_div_valid = 1'b0;
    logic [W-1:0]   ex_dividend = '0;
    logic [W-1:0]   ex_divisor = '0;
    logic           flush = 1'b0;
    logic           stall;
    logic           div_start;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_ready;
    logic [2*W-1:0] div_result;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           hilo_we;
    logic           div_by_zero;
    logic           timeout;

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(W), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_div_valid(ex_div_valid),
        .ex_dividend(ex_dividend), .ex_divisor(ex_divisor), .flush(flush),
        .stall(stall), .div_start(div_start), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_ready(div_ready), .div_result(div_result),
        .hi(hi), .lo(lo), .hilo_we(hilo_we), .div_by_zero(div_by_zero),
        .timeout(timeout)
    );

    // Divider model. m_lat is the number of cycles from the div_start cycle to the first ready cycle.
    int           m_lat = 2;
    bit           m_stuck = 1'b0;
    int           m_cnt;
    bit           m_busy;
    logic [W-1:0] m_a, m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_ready  <= 1'b0;
            div_result <= '0;
            m_busy     <= 1'b0;
            m_cnt      <= 0;
            m_a        <= '0;
            m_b        <= '0;
        end else if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= m_lat - 1;
            m_a    <= div_dividend;
            m_b    <= div_divisor;
        end else if (m_busy) begin
            div_ready <= 1'b0;
            if (m_cnt <= 1 && !m_stuck) begin
                div_ready  <= 1'b1;
                m_busy     <= 1'b0;
                div_result <= {m_a % m_b, m_a / m_b};
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   last_wb = -100;
    bit   tmo_ok = 1'b0;

    // Scoreboard monitor: every HI/LO write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hilo_we) begin
                last_wb = cyc;
                if (sb_q.size() == 0) begin
                    check("unexpected_hilo_we", hilo_we, 1'b0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("hi", hi, mon_e.hi);
                    check("lo", lo, mon_e.lo);
                    check("div_by_zero", div_by_zero, mon_e.dbz);
                end
            end else if (div_by_zero) begin
                check("dbz_without_we", div_by_zero, 1'b0);
            end
            if (timeout && !tmo_ok) check("unexpected_timeout", timeout, 1'b0);
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           rdy;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           stall_cyc;
    } vec_t;

    // Call this at posedge+#1 while the controller is IDLE. It holds the request
    // until stall drops, checking the stall length and the start pulse count.
    task automatic do_div(input vec_t v);
        int   n_stall = 0;
        int   n_start = 0;
        int   guard = 0;
        exp_t e;
        e.hi = v.hi;
        e.lo = v.lo;
        e.dbz = v.dbz;
        sb_q.push_back(e);
        m_lat        = v.rdy;
        ex_div_valid = 1'b1;
        ex_dividend  = v.a;
        ex_divisor   = v.b;
        @(negedge clk);
        while (stall && guard < 300) begin
            n_stall++;
            if (div_start) begin
                n_start++;
                check("start_gap_after_wb", (cyc - last_wb) >= 2, 1'b1);
            end
            guard++;
            @(negedge clk);
        end
        check("stall_released", stall, 1'b0);
        check("stall_cycles", n_stall, v.stall_cyc);
        check("start_pulses", n_start, (v.b == 0) ? 0 : 1);
        @(posedge clk);
        #1;
        check("wb_written", sb_q.size(), 0);
        check("hilo_we_one_cycle", hilo_we, 1'b0);
        ex_div_valid = 1'b0;
    endtask

    vec_t tbl[9];
    vec_t v;
    int   n;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         a            b         rdy  hi           lo           dbz   stall
        tbl[0] = '{16'd8,      16'd7,     17, 16'd1,      16'd1,      1'b0, 19};
        tbl[1] = '{16'd51,     16'd5,     4,  16'd1,      16'd10,     1'b0, 6};
        tbl[2] = '{16'd100,    16'd7,     2,  16'd2,      16'd14,     1'b0, 4};
        tbl[3] = '{16'd100,    16'd0,     2,  16'd100,    16'hFFFF,   1'b1, 1};
        tbl[4] = '{16'hFFFF,   16'd1,     3,  16'd0,      16'hFFFF,   1'b0, 5};
        tbl[5] = '{16'd0,      16'd5,     2,  16'd0,      16'd0,      1'b0, 4};
        tbl[6] = '{16'd0,      16'd0,     2,  16'd0,      16'hFFFF,   1'b1, 1};
        tbl[7] = '{16'hFFFF,   16'hFFFF,  2,  16'd0,      16'd1,      1'b0, 4};
        tbl[8] = '{16'd1000,   16'd33,    6,  16'd10,     16'd30,     1'b0, 8};

        // Reset state.
        #3;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_div_start", div_start, 0);
        check("rst_hilo_we", hilo_we, 0);
        check("rst_timeout", timeout, 0);
        ex_div_valid = 1'b1;
        #1;
        check("rst_stall_follows_valid", stall, 1'b1);
        ex_div_valid = 1'b0;
        #1;
        check("rst_stall_idle", stall, 1'b0);
        #17 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: the vectors run back to back, each issued on the cycle after the previous WB.
        for (int i = 0; i < 9; i++) do_div(tbl[i]);

        // A flush in IDLE blocks acceptance.
        ex_div_valid = 1'b1; ex_dividend = 16'd6; ex_divisor = 16'd3; flush = 1'b1;
        #1;
        check("idle_flush_stall", stall, 1'b0);
        @(posedge clk); #1;
        ex_div_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("idle_flush_no_start", div_start, 1'b0);

        // 40/3 flushed in WAIT, then 9/2 issued during DRAIN.
        m_lat = 20;
        ex_div_valid = 1'b1; ex_dividend = 16'd40; ex_divisor = 16'd3;
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("wait_flush_stall_drop", stall, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("drain_stall", stall, 1'b1);
        check("drain_hi_kept", hi, 16'd10);
        check("drain_lo_kept", lo, 16'd30);
        v = '{16'd9, 16'd2, 3, 16'd1, 16'd4, 1'b0, 21};
        do_div(v);

        // A flush in LAUNCH still issues the start pulse. The result is then drained without a write.
        m_lat = 3;
        ex_div_valid = 1'b1; ex_dividend = 16'd30; ex_divisor = 16'd4;
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        check("launch_flush_start", div_start, 1'b1);
        check("launch_flush_stall", stall, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; ex_div_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("launch_flush_hi_kept", hi, 16'd1);
        check("launch_flush_lo_kept", lo, 16'd4);

        // Timeout: the divider never becomes ready.
        m_stuck = 1'b1; tmo_ok = 1'b1; m_lat = 2;
        ex_div_valid = 1'b1; ex_dividend = 16'd5; ex_divisor = 16'd1;
        n = 0;
        @(negedge clk);
        while (!timeout && n < 200) begin
            n++;
            @(negedge clk);
        end
        ex_div_valid = 1'b0;
        check("timeout_cycle", n, 67);
        @(negedge clk);
        check("timeout_one_cycle", timeout, 1'b0);
        tmo_ok = 1'b0; m_stuck = 1'b0;
        @(posedge clk); #1;
        v = '{16'd77, 16'd6, 5, 16'd5, 16'd12, 1'b0, 7};
        do_div(v);

        // Asynchronous reset in WAIT, then a normal 8/7.
        m_lat = 30;
        ex_div_valid = 1'b1; ex_dividend = 16'd8; ex_divisor = 16'd7;
        repeat (5) @(posedge clk);
        #2;
        ex_div_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_div_dividend", div_dividend, 0);
        check("arst_div_divisor", div_divisor, 0);
        check("arst_div_start", div_start, 0);
        check("arst_hilo_we", hilo_we, 0);
        check("arst_div_by_zero", div_by_zero, 0);
        check("arst_timeout", timeout, 0);
        check("arst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_div(tbl[0]);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
